// File: rtl/tres_pkg.sv
// Shared types and helpers for the tic-tac-toe game-control stage.
package tres_pkg;

  typedef enum logic [1:0] {
    VACIA = 2'd0,
    JUG_X = 2'd1,
    JUG_O = 2'd2
  } celda_t;

  typedef celda_t [2:0][2:0] tablero_t;

  typedef enum logic [1:0] {
    INICIO,
    ESPERA_MOV,
    EVALUA,
    FIN
  } estado_t;

  typedef struct packed {
    logic [1:0] fila;
    logic [1:0] col;
  } pos_t;

  localparam int NUM_CELDAS = 9;

  // Board with every cell empty.
  function automatic tablero_t tablero_vacio();
    tablero_t t;
    for (int f = 0; f < 3; f++) begin
      for (int c = 0; c < 3; c++) begin
        t[f][c] = VACIA;
      end
    end
    return t;
  endfunction

  // First empty cell in row-major order; scanning backwards leaves the lowest hit.
  function automatic pos_t primera_vacia(input tablero_t t);
    pos_t p;
    p.fila = 2'd0;
    p.col  = 2'd0;
    for (int f = 2; f >= 0; f--) begin
      for (int c = 2; c >= 0; c--) begin
        if (t[f][c] == VACIA) begin
          p.fila = 2'(f);
          p.col  = 2'(c);
        end
      end
    end
    return p;
  endfunction

endpackage

// File: rtl/temporizador_turno.sv
// Per-turn down-counter: load has priority over decrement, expira flags the last cycle.
module temporizador_turno #(
  parameter int TIEMPO_TURNO = 20,
  parameter int TW           = $clog2(TIEMPO_TURNO + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          carga_i,
  input  logic          habilita_i,
  output logic [TW-1:0] cuenta_o,
  output logic          expira_o
);

  logic [TW-1:0] cuenta_q;

  // Reload on a new turn, otherwise count down while enabled and never wrap below zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cuenta_q <= '0;
    end else if (carga_i) begin
      cuenta_q <= TW'(TIEMPO_TURNO);
    end else if (habilita_i && (cuenta_q != '0)) begin
      cuenta_q <= cuenta_q - TW'(1);
    end
  end

  assign cuenta_o = cuenta_q;
  assign expira_o = (cuenta_q == TW'(1));

endmodule

// File: rtl/tablero_juego.sv
// Game-control stage: owns the 3x3 board, alternates X/O, applies turn timeouts
// and ends the game on a line reported by the downstream TresenFila checker.
module tablero_juego
  import tres_pkg::*;
#(
  parameter int  TIEMPO_TURNO = 500_000_000,
  localparam int TW           = $clog2(TIEMPO_TURNO + 1)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  iniciar,
  input  logic                  mov_valido,
  input  logic [1:0]            mov_fila,
  input  logic [1:0]            mov_col,
  input  logic                  ganador,
  output logic [2:0][2:0][1:0]  matriz_juego,
  output logic [1:0]            jugador_actual,
  output logic                  mov_aceptado,
  output logic                  mov_rechazado,
  output logic                  timeout,
  output logic                  fin_juego,
  output logic [1:0]            ganador_id,
  output logic                  empate,
  output logic [TW-1:0]         tiempo_restante
);

  estado_t    estado_q, estado_d;
  tablero_t   tablero_q, tablero_d;
  celda_t     jugador_q, jugador_d;
  logic [3:0] movs_q, movs_d;
  logic       aceptado_q, aceptado_d;
  logic       rechazado_q, rechazado_d;
  logic       timeout_q, timeout_d;
  logic       fin_q, fin_d;
  logic [1:0] ganadorId_q, ganadorId_d;
  logic       empate_q, empate_d;
  logic       cargaTimer, habilitaTimer, expira;
  logic       celdaLibre, movLegal;
  pos_t       autoPos;

  assign celdaLibre = (mov_fila != 2'd3) && (mov_col != 2'd3) &&
                      (tablero_q[mov_fila][mov_col] == VACIA);
  assign movLegal   = (estado_q == ESPERA_MOV) && mov_valido && celdaLibre;
  assign autoPos    = primera_vacia(tablero_q);

  temporizador_turno #(
    .TIEMPO_TURNO(TIEMPO_TURNO),
    .TW          (TW)
  ) u_temporizador (
    .clk       (clk),
    .rst_n     (rst_n),
    .carga_i   (cargaTimer),
    .habilita_i(habilitaTimer),
    .cuenta_o  (tiempo_restante),
    .expira_o  (expira)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) estado_q <= INICIO;
    else        estado_q <= estado_d;
  end

  // Next state: a move (player or automatic) always goes through one EVALUA cycle.
  always_comb begin
    estado_d = estado_q;
    case (estado_q)
      INICIO, FIN: if (iniciar) estado_d = ESPERA_MOV;
      ESPERA_MOV:  if (movLegal || expira) estado_d = EVALUA;
      EVALUA:      if (ganador || (movs_q == 4'(NUM_CELDAS))) estado_d = FIN;
                   else estado_d = ESPERA_MOV;
      default:     estado_d = INICIO;
    endcase
  end

  // Datapath and pulse decisions for the current state; a player move beats expiry.
  always_comb begin
    tablero_d     = tablero_q;
    jugador_d     = jugador_q;
    movs_d        = movs_q;
    aceptado_d    = 1'b0;
    rechazado_d   = mov_valido && !movLegal;
    timeout_d     = 1'b0;
    fin_d         = fin_q;
    ganadorId_d   = ganadorId_q;
    empate_d      = empate_q;
    cargaTimer    = 1'b0;
    habilitaTimer = 1'b0;
    case (estado_q)
      INICIO, FIN: begin
        if (iniciar) begin
          tablero_d   = tablero_vacio();
          jugador_d   = JUG_X;
          movs_d      = '0;
          fin_d       = 1'b0;
          ganadorId_d = 2'd0;
          empate_d    = 1'b0;
          cargaTimer  = 1'b1;
        end
      end
      ESPERA_MOV: begin
        habilitaTimer = 1'b1;
        if (movLegal) begin
          tablero_d[mov_fila][mov_col] = jugador_q;
          aceptado_d = 1'b1;
          movs_d     = (movs_q == 4'(NUM_CELDAS)) ? movs_q : movs_q + 4'd1;
        end else if (expira) begin
          tablero_d[autoPos.fila][autoPos.col] = jugador_q;
          timeout_d = 1'b1;
          movs_d    = (movs_q == 4'(NUM_CELDAS)) ? movs_q : movs_q + 4'd1;
        end
      end
      EVALUA: begin
        if (ganador) begin
          fin_d       = 1'b1;
          ganadorId_d = jugador_q;
        end else if (movs_q == 4'(NUM_CELDAS)) begin
          fin_d    = 1'b1;
          empate_d = 1'b1;
        end else begin
          jugador_d  = (jugador_q == JUG_X) ? JUG_O : JUG_X;
          cargaTimer = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Datapath registers; every output comes straight from one of these.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tablero_q   <= tablero_vacio();
      jugador_q   <= VACIA;
      movs_q      <= '0;
      aceptado_q  <= 1'b0;
      rechazado_q <= 1'b0;
      timeout_q   <= 1'b0;
      fin_q       <= 1'b0;
      ganadorId_q <= 2'd0;
      empate_q    <= 1'b0;
    end else begin
      tablero_q   <= tablero_d;
      jugador_q   <= jugador_d;
      movs_q      <= movs_d;
      aceptado_q  <= aceptado_d;
      rechazado_q <= rechazado_d;
      timeout_q   <= timeout_d;
      fin_q       <= fin_d;
      ganadorId_q <= ganadorId_d;
      empate_q    <= empate_d;
    end
  end

  assign matriz_juego   = tablero_q;
  assign jugador_actual = jugador_q;
  assign mov_aceptado   = aceptado_q;
  assign mov_rechazado  = rechazado_q;
  assign timeout        = timeout_q;
  assign fin_juego      = fin_q;
  assign ganador_id     = ganadorId_q;
  assign empate         = empate_q;

endmodule

// File: tb/tb_tablero_juego.sv
// Self-checking bench for tablero_juego: directed game scenarios plus random play,
// all outputs compared every cycle against a move-level reference model.
module tb_tablero_juego;

  localparam int T  = 20;
  localparam int TW = $clog2(T + 1);

  localparam int FASE_IDLE  = 0;
  localparam int FASE_JUEGA = 1;
  localparam int FASE_EVAL  = 2;
  localparam int FASE_FIN   = 3;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b1;
  logic                 iniciar = 1'b0;
  logic                 mov_valido = 1'b0;
  logic [1:0]           mov_fila = 2'd0;
  logic [1:0]           mov_col = 2'd0;
  logic                 ganador;
  logic [2:0][2:0][1:0] matriz_juego;
  logic [1:0]           jugador_actual;
  logic                 mov_aceptado, mov_rechazado, timeout, fin_juego, empate;
  logic [1:0]           ganador_id;
  logic [TW-1:0]        tiempo_restante;

  int numCompared   = 0;
  int numMismatched = 0;

  int mb[3][3];
  int mJug, mMovs, mFase, mTimer, mAcc, mRech, mTo, mFin, mGan, mEmp;

  // Free-running clock.
  always #5 clk = ~clk;

  tablero_juego #(.TIEMPO_TURNO(T)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .iniciar        (iniciar),
    .mov_valido     (mov_valido),
    .mov_fila       (mov_fila),
    .mov_col        (mov_col),
    .ganador        (ganador),
    .matriz_juego   (matriz_juego),
    .jugador_actual (jugador_actual),
    .mov_aceptado   (mov_aceptado),
    .mov_rechazado  (mov_rechazado),
    .timeout        (timeout),
    .fin_juego      (fin_juego),
    .ganador_id     (ganador_id),
    .empate         (empate),
    .tiempo_restante(tiempo_restante)
  );

  // Behavioural stand-in for TresenFila: any full line of one player.
  function automatic logic tresEnFila(input logic [2:0][2:0][1:0] m);
    logic r;
    r = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (m[i][0] != 2'd0 && m[i][0] == m[i][1] && m[i][1] == m[i][2]) r = 1'b1;
      if (m[0][i] != 2'd0 && m[0][i] == m[1][i] && m[1][i] == m[2][i]) r = 1'b1;
    end
    if (m[1][1] != 2'd0 && m[0][0] == m[1][1] && m[1][1] == m[2][2]) r = 1'b1;
    if (m[1][1] != 2'd0 && m[0][2] == m[1][1] && m[1][1] == m[2][0]) r = 1'b1;
    return r;
  endfunction

  // Winner signal follows the board combinationally, as the real checker does.
  always_comb ganador = tresEnFila(matriz_juego);

  task automatic checkOutput(input string tag, input int obs, input int exp);
    numCompared++;
    if (obs != exp) begin
      numMismatched++;
      $display("[TB] FAIL %s: observed %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Reference model: list of winning lines over cells numbered 0..8.
  function automatic bit modelGana();
    int lineas[8][3] = '{'{0,1,2}, '{3,4,5}, '{6,7,8}, '{0,3,6},
                         '{1,4,7}, '{2,5,8}, '{0,4,8}, '{2,4,6}};
    bit g;
    int a, b, c;
    g = 0;
    for (int l = 0; l < 8; l++) begin
      a = mb[lineas[l][0] / 3][lineas[l][0] % 3];
      b = mb[lineas[l][1] / 3][lineas[l][1] % 3];
      c = mb[lineas[l][2] / 3][lineas[l][2] % 3];
      if (a != 0 && a == b && b == c) g = 1;
    end
    return g;
  endfunction

  function automatic void modelReset();
    for (int f = 0; f < 3; f++) for (int c = 0; c < 3; c++) mb[f][c] = 0;
    mJug = 0; mMovs = 0; mFase = FASE_IDLE; mTimer = 0;
    mAcc = 0; mRech = 0; mTo = 0; mFin = 0; mGan = 0; mEmp = 0;
  endfunction

  // One clock of game rules applied to the model, given this cycle's inputs.
  function automatic void modelStep(input bit ini, input bit mv, input int f, input int c);
    bit legal;
    int k;
    mAcc = 0; mRech = 0; mTo = 0;
    legal = 0;
    if (mv && f < 3 && c < 3) legal = (mb[f][c] == 0);
    case (mFase)
      FASE_IDLE, FASE_FIN: begin
        if (mv) mRech = 1;
        if (ini) begin
          for (int i = 0; i < 9; i++) mb[i / 3][i % 3] = 0;
          mJug = 1; mMovs = 0; mTimer = T;
          mFin = 0; mGan = 0; mEmp = 0;
          mFase = FASE_JUEGA;
        end
      end
      FASE_JUEGA: begin
        if (legal) begin
          mb[f][c] = mJug;
          mMovs++;
          mAcc = 1;
          mFase = FASE_EVAL;
        end else begin
          if (mv) mRech = 1;
          if (mTimer == 1) begin
            k = 0;
            while (mb[k / 3][k % 3] != 0) k++;
            mb[k / 3][k % 3] = mJug;
            mMovs++;
            mTo = 1;
            mFase = FASE_EVAL;
          end
        end
        mTimer--;
      end
      default: begin
        if (mv) mRech = 1;
        if (modelGana()) begin
          mFin = 1; mGan = mJug; mFase = FASE_FIN;
        end else if (mMovs == 9) begin
          mFin = 1; mEmp = 1; mFase = FASE_FIN;
        end else begin
          mJug = 3 - mJug; mTimer = T; mFase = FASE_JUEGA;
        end
      end
    endcase
  endfunction

  task automatic checkAll();
    int expBoard;
    expBoard = 0;
    for (int i = 0; i < 9; i++) expBoard = expBoard | (mb[i / 3][i % 3] << (2 * i));
    checkOutput("matriz_juego",    int'(matriz_juego),    expBoard);
    checkOutput("jugador_actual",  int'(jugador_actual),  mJug);
    checkOutput("mov_aceptado",    int'(mov_aceptado),    mAcc);
    checkOutput("mov_rechazado",   int'(mov_rechazado),   mRech);
    checkOutput("timeout",         int'(timeout),         mTo);
    checkOutput("fin_juego",       int'(fin_juego),       mFin);
    checkOutput("ganador_id",      int'(ganador_id),      mGan);
    checkOutput("empate",          int'(empate),          mEmp);
    checkOutput("tiempo_restante", int'(tiempo_restante), mTimer);
  endtask

  task automatic applyStimulus(input bit ini, input bit mv, input int f, input int c);
    @(negedge clk);
    iniciar    = ini;
    mov_valido = mv;
    mov_fila   = f[1:0];
    mov_col    = c[1:0];
    modelStep(ini, mv, f, c);
    @(posedge clk);
    #1;
    checkAll();
  endtask

  task automatic doReset();
    @(negedge clk);
    rst_n = 1'b0;
    iniciar = 1'b0; mov_valido = 1'b0; mov_fila = 2'd0; mov_col = 2'd0;
    modelReset();
    #1;
    checkAll();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic idle(input int n);
    repeat (n) applyStimulus(0, 0, 0, 0);
  endtask

  task automatic playMove(input int f, input int c);
    applyStimulus(0, 1, f, c);
    applyStimulus(0, 0, 0, 0);
  endtask

  // Directed scenarios first, then randomized play.
  initial begin
    int movProb;
    bit ini, mv;
    modelReset();

    // Reset values and a win for X on the top row.
    doReset();
    applyStimulus(1, 0, 0, 0);
    playMove(0, 0); playMove(1, 0); playMove(0, 1); playMove(1, 1);
    applyStimulus(0, 1, 0, 2);
    checkOutput("t1_aceptado", int'(mov_aceptado), 1);
    applyStimulus(0, 0, 0, 0);
    checkOutput("t1_fin", int'(fin_juego), 1);
    checkOutput("t1_ganador", int'(ganador_id), 1);

    // Frozen board in FIN, then a fresh game.
    applyStimulus(0, 1, 2, 2);
    checkOutput("fin_rechazo", int'(mov_rechazado), 1);
    applyStimulus(1, 0, 0, 0);
    checkOutput("fin_reinicio_tablero", int'(matriz_juego), 0);
    checkOutput("fin_reinicio_jugador", int'(jugador_actual), 1);

    // Occupied cell and out-of-range row are rejected.
    playMove(1, 1);
    applyStimulus(0, 1, 1, 1);
    checkOutput("t2_rechazo_ocupada", int'(mov_rechazado), 1);
    checkOutput("t2_celda", int'(matriz_juego[1][1]), 1);
    applyStimulus(0, 1, 3, 0);
    checkOutput("t2_rechazo_fila", int'(mov_rechazado), 1);
    checkOutput("t2_jugador", int'(jugador_actual), 2);

    // Timeout places X at [0][0].
    doReset();
    applyStimulus(1, 0, 0, 0);
    idle(20);
    checkOutput("t3_timeout", int'(timeout), 1);
    checkOutput("t3_celda", int'(matriz_juego[0][0]), 1);
    idle(1);
    checkOutput("t3_jugador", int'(jugador_actual), 2);
    checkOutput("t3_recarga", int'(tiempo_restante), T);

    // Full board without a line.
    doReset();
    applyStimulus(1, 0, 0, 0);
    playMove(0, 0); playMove(0, 1); playMove(0, 2); playMove(1, 1); playMove(1, 0);
    playMove(1, 2); playMove(2, 1); playMove(2, 0); playMove(2, 2);
    checkOutput("t4_empate", int'(empate), 1);
    checkOutput("t4_ganador", int'(ganador_id), 0);
    checkOutput("t4_fin", int'(fin_juego), 1);

    // Player move on the expiry cycle wins over the automatic move.
    doReset();
    applyStimulus(1, 0, 0, 0);
    idle(19);
    checkOutput("t5_tiempo", int'(tiempo_restante), 1);
    applyStimulus(0, 1, 1, 1);
    checkOutput("t5_aceptado", int'(mov_aceptado), 1);
    checkOutput("t5_sin_timeout", int'(timeout), 0);
    checkOutput("t5_celda", int'(matriz_juego[1][1]), 1);

    // Reset mid-game, then moves are refused in INICIO.
    doReset();
    applyStimulus(1, 0, 0, 0);
    playMove(0, 0); playMove(2, 2); playMove(1, 0);
    doReset();
    checkOutput("t6_tablero", int'(matriz_juego), 0);
    applyStimulus(0, 1, 0, 0);
    checkOutput("t6_rechazo", int'(mov_rechazado), 1);
    checkOutput("t6_tablero_post", int'(matriz_juego), 0);

    // Random play with varying move density so timeouts also occur.
    for (int blk = 0; blk < 8; blk++) begin
      movProb = (blk % 2 == 0) ? 2 : 30;
      for (int i = 0; i < 500; i++) begin
        if ($urandom_range(0, 599) == 0) doReset();
        ini = ($urandom_range(0, 7) == 0);
        mv  = ($urandom_range(0, movProb - 1) == 0);
        applyStimulus(ini, mv, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", numCompared, numMismatched);
    $finish;
  end

endmodule
